// File: rtl/mlp_pkg.sv
// mlp_pkg: definitions shared by the MLP datapath stages (MAC, layer,
// argmax). Holds the default fixed-point format, the argmax FSM state
// encoding and the helper that sizes index fields.
package mlp_pkg;

  // Default Q8.8 format shared by the MAC, layer and argmax stages.
  localparam int FP_TOTAL_BITS_DEFAULT = 16;
  localparam int FP_FRAC_BITS_DEFAULT  = 8;

  // Argmax controller states. The encoding is fixed so that legacy code
  // can keep using plain 2-bit constants.
  typedef enum logic [1:0] {
    ARGMAX_IDLE = 2'd0,
    ARGMAX_SCAN = 2'd1,
    ARGMAX_HOLD = 2'd2
  } argmax_state_t;

  // Bits needed to index n items, never less than one so that a
  // single-item configuration still has a real port.
  function automatic int clog2_min1(input int n);
    int w;
    if (n > 2) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/argmax_select_if.sv
// argmax_select_if: bundles the score capture inputs and the result
// valid/ready handshake of the argmax stage.
//   in_done   - level done from the layer (rising edge = new scores)
//   scores    - packed signed scores, element 0 in the low bits
//   busy      - stage owns a captured score set
//   out_valid / out_ready - result handshake
//   class_idx / max_score - winning index and its score
//   overrun   - sticky flag, a done edge arrived while busy
// master = the environment side, slave = the argmax stage.
interface argmax_select_if
  import mlp_pkg::*;
#(
  parameter int NUM_CLASSES   = 3,
  parameter int FP_TOTAL_BITS = FP_TOTAL_BITS_DEFAULT
);

  localparam int IDX_W = clog2_min1(NUM_CLASSES);

  logic                                      in_done;
  logic [NUM_CLASSES-1:0][FP_TOTAL_BITS-1:0] scores;
  logic                                      busy;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [IDX_W-1:0]                          class_idx;
  logic [FP_TOTAL_BITS-1:0]                  max_score;
  logic                                      overrun;

  modport master (
    output in_done, scores, out_ready,
    input  busy, out_valid, class_idx, max_score, overrun
  );

  modport slave (
    input  in_done, scores, out_ready,
    output busy, out_valid, class_idx, max_score, overrun
  );

endinterface

// File: rtl/argmax_select.sv
// argmax_select: final classification stage of the MLP datapath.
// On a rising edge of the layer's level done it captures all scores,
// walks them one per clock with a signed compare, and presents the
// winning index and score until the consumer accepts them.
// Ports:
//   clk   - single clock
//   reset - asynchronous, active-low
//   bus   - argmax_select_if.slave (capture inputs, result handshake,
//           busy and sticky overrun)
// All outputs come straight from registers.
module argmax_select
  import mlp_pkg::*;
#(
  parameter int NUM_CLASSES   = 3,
  parameter int FP_TOTAL_BITS = FP_TOTAL_BITS_DEFAULT,
  parameter int FP_FRAC_BITS  = FP_FRAC_BITS_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  argmax_select_if.slave bus
);

  localparam int               IDX_W    = clog2_min1(NUM_CLASSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  localparam logic [1:0] IDLE_ST = ARGMAX_IDLE;
  localparam logic [1:0] SCAN_ST = ARGMAX_SCAN;
  localparam logic [1:0] HOLD_ST = ARGMAX_HOLD;

  // Reject configurations the index and score fields cannot represent.
  // The fractional width never affects an ordering compare, so it is
  // only range-checked here.
  if ((NUM_CLASSES < 1) || (NUM_CLASSES > 256)) begin : g_bad_num_classes
    $error("argmax_select: NUM_CLASSES must be 1..256");
  end
  if ((FP_FRAC_BITS < 0) || (FP_FRAC_BITS >= FP_TOTAL_BITS)) begin : g_bad_frac_bits
    $error("argmax_select: FP_FRAC_BITS must be 0..FP_TOTAL_BITS-1");
  end

  logic [1:0]               state_r;
  logic                     done_q_r;
  logic [FP_TOTAL_BITS-1:0] score_arr_r [NUM_CLASSES];
  logic [FP_TOTAL_BITS-1:0] best_r;
  logic [IDX_W-1:0]         best_idx_r;
  logic [IDX_W-1:0]         cnt_r;
  logic                     busy_r;
  logic                     out_valid_r;
  logic                     overrun_r;
  logic [IDX_W-1:0]         class_idx_r;
  logic [FP_TOTAL_BITS-1:0] max_score_r;

  logic                     rise_s;
  logic [FP_TOTAL_BITS-1:0] cand_s;
  logic                     greater_s;
  logic [IDX_W-1:0]         win_idx_s;
  logic [FP_TOTAL_BITS-1:0] win_score_s;

  // Done edge detect and the running-best update for the current scan slot.
  always_comb begin
    rise_s    = bus.in_done & ~done_q_r;
    cand_s    = score_arr_r[cnt_r];
    // Strictly greater only: a tie keeps the earlier (lower) index.
    greater_s = $signed(cand_s) > $signed(best_r);
    if (greater_s) begin
      win_idx_s   = cnt_r;
      win_score_s = cand_s;
    end else begin
      win_idx_s   = best_idx_r;
      win_score_s = best_r;
    end
  end

  // Capture, sequential scan and result hold; reset discards any partial scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE_ST;
      done_q_r    <= 1'b0;
      best_r      <= '0;
      best_idx_r  <= '0;
      cnt_r       <= '0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      class_idx_r <= '0;
      max_score_r <= '0;
      for (int j = 0; j < NUM_CLASSES; j++) begin
        score_arr_r[j] <= '0;
      end
    end else begin
      done_q_r <= bus.in_done;

      // Any done edge outside IDLE is lost, including one landing on the
      // acceptance cycle; remember it until reset.
      if (rise_s && (state_r != IDLE_ST)) begin
        overrun_r <= 1'b1;
      end else begin
        overrun_r <= overrun_r;
      end

      case (state_r)
        IDLE_ST: begin
          if (rise_s) begin
            for (int j = 0; j < NUM_CLASSES; j++) begin
              score_arr_r[j] <= bus.scores[j];
            end
            best_r     <= bus.scores[0];
            best_idx_r <= '0;
            cnt_r      <= IDX_W'(1);
            busy_r     <= 1'b1;
            if (NUM_CLASSES == 1) begin
              // Nothing to compare: the only score is the winner.
              state_r     <= HOLD_ST;
              out_valid_r <= 1'b1;
              class_idx_r <= '0;
              max_score_r <= bus.scores[0];
            end else begin
              state_r <= SCAN_ST;
            end
          end else begin
            state_r <= IDLE_ST;
          end
        end

        SCAN_ST: begin
          best_r     <= win_score_s;
          best_idx_r <= win_idx_s;
          if (cnt_r == LAST_IDX) begin
            // Last slot: publish the result including this compare.
            state_r     <= HOLD_ST;
            out_valid_r <= 1'b1;
            class_idx_r <= win_idx_s;
            max_score_r <= win_score_s;
          end else begin
            cnt_r <= cnt_r + IDX_W'(1);
          end
        end

        HOLD_ST: begin
          if (bus.out_ready) begin
            state_r     <= IDLE_ST;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end else begin
            state_r <= HOLD_ST;
          end
        end

        default: begin
          state_r     <= IDLE_ST;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.class_idx = class_idx_r;
  assign bus.max_score = max_score_r;
  assign bus.overrun   = overrun_r;

endmodule
